// File: rtl/axi_ram_responder.sv
// axi_ram_responder: single-outstanding AXI4 subordinate backed by on-chip 64-bit synchronous RAM.
// Optional macro AXI_RAM_RANGE_CHECK_EN: beats at or above MEM_DEPTH*8 bytes get SLVERR instead of aliasing.
module axi_ram_responder #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   i_awid,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [63:0]           i_wdata,
    input  logic [7:0]            i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [ID_WIDTH-1:0]   o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ID_WIDTH-1:0]   i_arid,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [2:0]            i_arsize,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [ID_WIDTH-1:0]   o_rid,
    output logic [63:0]           o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic PRIO_WRITE = 1'b0;
    localparam logic PRIO_READ  = 1'b1;

    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RREAD, S_RDATA} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [2:0]            size_q, size_d;
    logic                  fixed_q, fixed_d;
    logic                  err_q, err_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [63:0]           rdata_q;
    logic [63:0]           mem [MEM_DEPTH];

    logic [IDX_W-1:0]      word_idx;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_beat;
    logic                  oor;
    logic                  mem_we;
    logic                  mem_re;

    assign word_idx  = addr_q[IDX_W+2:3];
    assign last_beat = (beat_q == len_q);
    assign addr_next = fixed_q ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);
`ifdef AXI_RAM_RANGE_CHECK_EN
    assign oor = (addr_q[ADDR_WIDTH-1:IDX_W+3] != '0);
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        fixed_d   = fixed_q;
        err_d     = err_q;
        rresp_d   = rresp_q;
        o_awready = 1'b0;
        o_arready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        o_rvalid  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // When both requests are pending, exactly one ready is raised (alternating priority).
                o_awready = !rst && (!i_arvalid || prio_q == PRIO_WRITE);
                o_arready = !rst && (!i_awvalid || prio_q == PRIO_READ);
                if (i_awvalid && o_awready) begin
                    id_d    = i_awid;
                    addr_d  = i_awaddr;
                    len_d   = i_awlen;
                    size_d  = i_awsize;
                    fixed_d = (i_awburst == 2'b00);
                    err_d   = i_awburst[1];
                    beat_d  = '0;
                    prio_d  = PRIO_READ;
                    state_d = S_WDATA;
                end else if (i_arvalid && o_arready) begin
                    id_d    = i_arid;
                    addr_d  = i_araddr;
                    len_d   = i_arlen;
                    size_d  = i_arsize;
                    fixed_d = (i_arburst == 2'b00);
                    err_d   = i_arburst[1];
                    beat_d  = '0;
                    prio_d  = PRIO_WRITE;
                    state_d = S_RREAD;
                end
            end
            S_WDATA: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    mem_we = !rst && !oor;
                    if ((i_wlast != last_beat) || oor) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = S_WRESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            S_WRESP: begin
                o_bvalid = 1'b1;
                if (i_bready) state_d = S_IDLE;
            end
            S_RREAD: begin
                mem_re  = 1'b1;
                rresp_d = (err_q || oor) ? 2'b10 : 2'b00;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = S_RREAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= PRIO_WRITE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            rresp_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            fixed_q <= fixed_d;
            err_q   <= err_d;
            rresp_q <= rresp_d;
        end
    end

    // Storage has no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wstrb[b]) mem[word_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= oor ? 64'd0 : mem[word_idx];
        end
    end

    assign o_bid   = id_q;
    assign o_bresp = err_q ? 2'b10 : 2'b00;
    assign o_rid   = id_q;
    assign o_rdata = rdata_q;
    assign o_rresp = rresp_q;
    assign o_rlast = (state_q == S_RDATA) && last_beat;

endmodule

// File: tb/tb_axi_ram_responder.sv
// tb_axi_ram_responder: directed and randomized AXI traffic checked against a byte-level memory model.
module tb_axi_ram_responder;
  localparam int MEM_DEPTH = 8192;
  localparam int TMO = 50;
`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] i_awid = '0, i_arid = '0, o_bid, o_rid;
  logic [31:0] i_awaddr = '0, i_araddr = '0;
  logic [7:0] i_awlen = '0, i_arlen = '0, i_wstrb = '0;
  logic [2:0] i_awsize = '0, i_arsize = '0;
  logic [1:0] i_awburst = '0, i_arburst = '0, o_bresp, o_rresp;
  logic i_awvalid = 1'b0, i_wlast = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic i_arvalid = 1'b0, i_rready = 1'b0;
  logic o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
  logic [63:0] i_wdata = '0, o_rdata;

  int errors = 0;
  int checks = 0;

  logic [63:0] model_mem [int];
  logic [7:0]  model_vld [int];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  axi_ram_responder #(.ID_WIDTH(6), .ADDR_WIDTH(32), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: beat address follows burst rules directly, word = byte address / 8 modulo depth.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu, input int i);
    if (bu == 2'b00) return a;
    return a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 3) & 32'(MEM_DEPTH - 1));
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    bit hi;
    hi = (a >= 32'(MEM_DEPTH * 8));
    return RANGE_EN && hi;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] v);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = v[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic w_beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    int n;
    int w;
    i_wdata = d; i_wstrb = s; i_wlast = l; i_wvalid = 1'b1;
    #1;
    n = 0;
    while (!o_wready && n < TMO) begin @(negedge clk); #1; n++; end
    check("w_hs_timeout", 64'(n < TMO), 64'd1);
    @(posedge clk);
    if (!out_of_range(a)) begin
      w = word_of(a);
      if (!model_mem.exists(w)) begin model_mem[w] = '0; model_vld[w] = '0; end
      for (int b = 0; b < 8; b++) begin
        if (s[b]) begin
          model_mem[w][b*8 +: 8] = d[b*8 +: 8];
          model_vld[w][b] = 1'b1;
        end
      end
    end
    @(negedge clk);
    i_wvalid = 1'b0; i_wlast = 1'b0;
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clk);
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    #1;
    n = 0;
    while (!o_awready && n < TMO) begin @(negedge clk); #1; n++; end
    check("aw_hs_timeout", 64'(n < TMO), 64'd1);
    @(posedge clk);
    @(negedge clk);
    i_awvalid = 1'b0;
  endtask

  task automatic b_take(input logic [5:0] id, input logic [1:0] resp, input int stall);
    int n;
    #1;
    n = 0;
    while (!o_bvalid && n < TMO) begin @(negedge clk); #1; n++; end
    check("b_timeout", 64'(n < TMO), 64'd1);
    repeat (stall) begin
      check("bid_stall", 64'(o_bid), 64'(id));
      check("bresp_stall", 64'(o_bresp), 64'(resp));
      @(negedge clk); #1;
    end
    check("bvalid", 64'(o_bvalid), 64'd1);
    check("bid", 64'(o_bid), 64'(id));
    check("bresp", 64'(o_bresp), 64'(resp));
    i_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_bready = 1'b0;
    #1;
    check("bvalid_drop", 64'(o_bvalid), 64'd0);
  endtask

  // Write burst from wd/ws; bad_last flips wlast on that beat index (-1 for none).
  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_last);
    logic [31:0] a;
    bit exp_err;
    exp_err = burst[1];
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, burst, i);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      if (i == bad_last || out_of_range(a)) exp_err = 1'b1;
      w_beat(a, wd[i], ws[i], (i == int'(len)) ^ (i == bad_last));
    end
    b_take(id, exp_err ? 2'b10 : 2'b00, $urandom_range(0, 2));
  endtask

  task automatic r_beat(input logic [5:0] id, input logic [31:0] a, input logic [1:0] burst,
                        input logic last, input int stall);
    int n;
    int w;
    logic [63:0] exp_d, m;
    logic [1:0] exp_r;
    #1;
    n = 0;
    while (!o_rvalid && n < TMO) begin @(negedge clk); #1; n++; end
    check("r_timeout", 64'(n < TMO), 64'd1);
    w = word_of(a);
    exp_r = (burst[1] || out_of_range(a)) ? 2'b10 : 2'b00;
    if (out_of_range(a)) begin
      exp_d = '0; m = '1;
    end else if (model_mem.exists(w)) begin
      exp_d = model_mem[w]; m = byte_mask(model_vld[w]);
    end else begin
      exp_d = '0; m = '0;
    end
    repeat (stall) begin
      check("rvalid_stall", 64'(o_rvalid), 64'd1);
      check("rdata_stall", o_rdata & m, exp_d & m);
      check("rid_stall", 64'(o_rid), 64'(id));
      check("rlast_stall", 64'(o_rlast), 64'(last));
      @(negedge clk); #1;
    end
    check("rdata", o_rdata & m, exp_d & m);
    check("rresp", 64'(o_rresp), 64'(exp_r));
    check("rlast", 64'(o_rlast), 64'(last));
    check("rid", 64'(o_rid), 64'(id));
    i_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_rready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    int n;
    @(negedge clk);
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    #1;
    n = 0;
    while (!o_arready && n < TMO) begin @(negedge clk); #1; n++; end
    check("ar_hs_timeout", 64'(n < TMO), 64'd1);
    @(posedge clk);
    @(negedge clk);
    i_arvalid = 1'b0;
    #1;
    check("rvalid_1cyc", 64'(o_rvalid), 64'd0);
    @(negedge clk); #1;
    check("rvalid_2cyc", 64'(o_rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      r_beat(id, beat_addr(addr, size, burst, i), burst, i == int'(len),
             (i == stall_beat) ? 5 : int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    int bad;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_awready", 64'(o_awready), 64'd0);
    check("rst_arready", 64'(o_arready), 64'd0);
    check("rst_valids", 64'({o_wready, o_bvalid, o_rvalid, o_rlast}), 64'd0);
    check("rst_outs", 64'({o_bid, o_bresp, o_rid, o_rresp}), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    rst = 1'b0;
    #1;
    check("idle_awready", 64'(o_awready), 64'd1);
    check("idle_arready", 64'(o_arready), 64'd1);

    // Simultaneous AW/AR after reset: write wins, read accepted in first idle cycle after B
    @(negedge clk);
    i_awid = 6'd5; i_awaddr = 32'h400; i_awlen = 8'd0; i_awsize = 3'd3; i_awburst = 2'b01;
    i_awvalid = 1'b1;
    i_arid = 6'd9; i_araddr = 32'h400; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'b01;
    i_arvalid = 1'b1;
    #1;
    check("sim_awready", 64'(o_awready), 64'd1);
    check("sim_arready", 64'(o_arready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    i_awvalid = 1'b0;
    w_beat(32'h400, 64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1);
    #1;
    check("sim_bvalid", 64'(o_bvalid), 64'd1);
    check("sim_arready_busy", 64'(o_arready), 64'd0);
    check("sim_bid", 64'(o_bid), 64'd5);
    i_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_bready = 1'b0;
    #1;
    check("sim_arready_idle", 64'(o_arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    i_arvalid = 1'b0;
    r_beat(6'd9, 32'h400, 2'b01, 1'b1, 0);

    // Single write then read
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
    axi_write(6'd3, 32'h100, 8'd0, 3'd3, 2'b01, -1);
    axi_read(6'd7, 32'h100, 8'd0, 3'd3, 2'b01, -1);

    // Strobed burst over a zeroed region, then read with a 5-cycle stall on beat 1
    for (int i = 0; i < 4; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
    axi_write(6'd1, 32'h200, 8'd3, 3'd3, 2'b01, -1);
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, 24'($urandom), 8'(8'h11 * (i + 1))};
      ws[i] = 8'h01;
    end
    axi_write(6'd2, 32'h200, 8'd3, 3'd3, 2'b01, -1);
    axi_read(6'd4, 32'h200, 8'd3, 3'd3, 2'b01, 1);

    // Early wlast on beat 1 of a 3-beat burst
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(6'd6, 32'h280, 8'd2, 3'd3, 2'b01, 1);
    axi_read(6'd6, 32'h280, 8'd2, 3'd3, 2'b01, -1);

    // Reset during beat 2 of 4: preload, then abort an overwrite
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(6'd8, 32'h300, 8'd3, 3'd3, 2'b01, -1);
    aw_send(6'd10, 32'h300, 8'd3, 3'd3, 2'b01);
    w_beat(32'h300, 64'h1111_0000_0000_1111, 8'hFF, 1'b0);
    w_beat(32'h308, 64'h2222_0000_0000_2222, 8'hFF, 1'b0);
    i_wdata = 64'h3333_0000_0000_3333; i_wstrb = 8'hFF; i_wvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("abort_readies", 64'({o_awready, o_arready, o_wready}), 64'd0);
    check("abort_valids", 64'({o_bvalid, o_rvalid}), 64'd0);
    rst = 1'b0; i_wvalid = 1'b0;
    repeat (3) begin @(negedge clk); #1; check("abort_no_b", 64'(o_bvalid), 64'd0); end
    axi_read(6'd11, 32'h300, 8'd3, 3'd3, 2'b01, -1);

    // Range check / aliasing at 0x10000
    wd[0] = 64'hA5A5_5A5A_0F0F_F0F0; ws[0] = 8'hFF;
    axi_write(6'd12, 32'h0, 8'd0, 3'd3, 2'b01, -1);
    axi_read(6'd13, 32'h1_0000, 8'd0, 3'd3, 2'b01, -1);

    // Randomized traffic over a small region, with narrow sizes, fixed/wrap bursts and aliasing
    for (int t = 0; t < 40; t++) begin
      addr = 32'h1000 + 32'($urandom_range(0, 31) * 8) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h1_0000;
      len = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: burst = 2'b00;
        1: burst = 2'b10;
        2: burst = 2'b11;
        default: burst = 2'b01;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        end
        bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        axi_write(6'($urandom), addr, len, size, burst, bad);
      end else begin
        axi_read(6'($urandom), addr, len, size, burst, int'($urandom_range(0, 8)) - 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
